// File: rtl/pat_gen_seq_pkg.sv
// Shared types for the pattern-generator slice.
//   pg_state_e  : sequencer states (IDLE/RUN/DONE)
//   tbl_entry_t : one table entry {addr, data}
//   idx_width() : index width for an N-entry table (at least 1 bit)
package pat_gen_pkg;

  localparam int unsigned PG_ADDR_WIDTH = 32;
  localparam int unsigned PG_DATA_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } pg_state_e;

  typedef struct packed {
    logic [PG_ADDR_WIDTH-1:0] addr;
    logic [PG_DATA_WIDTH-1:0] data;
  } tbl_entry_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pat_gen_seq_if.sv
// Word stream from the pattern sequencer to the pattern consumer.
//   si_addr_o      : entry address      (master -> slave)
//   ctl_pat_data_o : entry data, wide   (master -> slave)
//   cfg_pat_gen_o  : word valid         (master -> slave)
//   nopg_i         : consumer stall     (slave -> master)
interface pat_gen_seq_if #(
  parameter int unsigned ADDR_WIDTH          = 32,
  parameter int unsigned SUB_REGS_DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]          si_addr_o;
  logic [SUB_REGS_DATA_WIDTH-1:0] ctl_pat_data_o;
  logic                           cfg_pat_gen_o;
  logic                           nopg_i;

  modport master (
    output si_addr_o,
    output ctl_pat_data_o,
    output cfg_pat_gen_o,
    input  nopg_i
  );

  modport slave (
    input  si_addr_o,
    input  ctl_pat_data_o,
    input  cfg_pat_gen_o,
    output nopg_i
  );
endinterface

// File: rtl/pat_gen_seq_tbl.sv
// pat_tbl: NUM_REGS-entry address/data register array, not reset.
//   clk_i      : clock
//   we_i       : write strobe; out-of-range indices are dropped
//   wr_idx_i   : write index
//   wr_entry_i : write entry
//   rd_idx_i   : read index
//   rd_entry_o : read entry (a same-cycle write to rd_idx_i is forwarded)
module pat_tbl
  import pat_gen_pkg::*;
#(
  parameter  int unsigned NUM_REGS = 21,
  localparam int unsigned IW       = idx_width(NUM_REGS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [IW-1:0] wr_idx_i,
  input  tbl_entry_t    wr_entry_i,
  input  logic [IW-1:0] rd_idx_i,
  output tbl_entry_t    rd_entry_o
);

  tbl_entry_t mem [NUM_REGS];
  logic       wr_ok;

  assign wr_ok = we_i && (32'(wr_idx_i) < NUM_REGS);

  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem[wr_idx_i] <= wr_entry_i;
    end
  end

  // Forwarding lets a write land in the word captured on the same edge.
  always_comb begin
    rd_entry_o = mem[rd_idx_i];
    if (wr_ok && (wr_idx_i == rd_idx_i)) begin
      rd_entry_o = wr_entry_i;
    end
  end

endmodule

// File: rtl/pat_gen_seq.sv
// pat_gen_seq: plays a programmable address/data table out as a word stream.
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   tbl_we_i/idx/addr/data : table write port
//   num_i, loops_i         : entries per pass, extra passes
//   start_i, abort_i       : run control
//   pg (master)            : si_addr_o, ctl_pat_data_o, cfg_pat_gen_o, nopg_i
//   busy_o, done_o, err_o  : status (err_o sticky until next valid start)
module pat_gen_seq
  import pat_gen_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH          = PG_ADDR_WIDTH,
  parameter  int unsigned DATA_WIDTH          = PG_DATA_WIDTH,
  parameter  int unsigned NUM_REGS            = 21,
  parameter  int unsigned SUB_REGS_DATA_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH,
  localparam int unsigned IW                  = idx_width(NUM_REGS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  tbl_we_i,
  input  logic [IW-1:0]         tbl_idx_i,
  input  logic [ADDR_WIDTH-1:0] tbl_addr_i,
  input  logic [DATA_WIDTH-1:0] tbl_data_i,
  input  logic [IW:0]           num_i,
  input  logic [7:0]            loops_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  pat_gen_seq_if.master         pg,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  pg_state_e   state_q, state_n;
  logic [IW-1:0] idx_q, idx_n;
  logic [IW:0]   num_q, num_n;
  logic [7:0]    pass_q, pass_n;
  logic          err_n;
  logic          load;
  logic [IW-1:0] rd_idx;
  logic          xfer;
  logic          num_ok;
  tbl_entry_t    wr_entry;
  tbl_entry_t    rd_entry;

  assign wr_entry = '{addr: tbl_addr_i, data: tbl_data_i};
  assign num_ok   = (num_i != '0) && (32'(num_i) <= NUM_REGS);
  assign xfer     = pg.cfg_pat_gen_o && !pg.nopg_i;

  pat_tbl #(
    .NUM_REGS (NUM_REGS)
  ) u_tbl (
    .clk_i      (clk_i),
    .we_i       (tbl_we_i),
    .wr_idx_i   (tbl_idx_i),
    .wr_entry_i (wr_entry),
    .rd_idx_i   (rd_idx),
    .rd_entry_o (rd_entry)
  );

  // Output words are captured from the entry being advanced to, so a stall
  // holds the old word even if its table slot is rewritten meanwhile.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    num_n   = num_q;
    pass_n  = pass_q;
    err_n   = err_o;
    load    = 1'b0;
    rd_idx  = '0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (num_ok) begin
            state_n = RUN;
            num_n   = num_i;
            pass_n  = loops_i;
            idx_n   = '0;
            err_n   = 1'b0;
            load    = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (xfer) begin
          if ({1'b0, idx_q} == (num_q - 1'b1)) begin
            idx_n = '0;
            if (pass_q == '0) begin
              state_n = DONE;
            end else begin
              pass_n = pass_q - 8'd1;
              load   = 1'b1;
            end
          end else begin
            idx_n  = idx_q + 1'b1;
            rd_idx = idx_q + 1'b1;
            load   = 1'b1;
          end
        end
        if (abort_i) begin
          state_n = IDLE;
          load    = 1'b0;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q           <= IDLE;
      idx_q             <= '0;
      num_q             <= '0;
      pass_q            <= '0;
      err_o             <= 1'b0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      pg.cfg_pat_gen_o  <= 1'b0;
      pg.si_addr_o      <= '0;
      pg.ctl_pat_data_o <= '0;
    end else begin
      state_q          <= state_n;
      idx_q            <= idx_n;
      num_q            <= num_n;
      pass_q           <= pass_n;
      err_o            <= err_n;
      busy_o           <= (state_n == RUN);
      done_o           <= (state_n == DONE);
      pg.cfg_pat_gen_o <= (state_n == RUN);
      if (load) begin
        pg.si_addr_o      <= rd_entry.addr;
        pg.ctl_pat_data_o <= SUB_REGS_DATA_WIDTH'(rd_entry.data);
      end
    end
  end

endmodule

// File: tb/tb_pat_gen_seq.sv
module tb_pat_gen_seq;

  logic        clk;
  logic        rst_ni;
  logic        tbl_we;
  logic [4:0]  tbl_idx;
  logic [31:0] tbl_addr;
  logic [11:0] tbl_data;
  logic [5:0]  num;
  logic [7:0]  loops;
  logic        start;
  logic        abort;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;

  pat_gen_seq_if #(.ADDR_WIDTH(32), .SUB_REGS_DATA_WIDTH(32)) pg_if ();

  pat_gen_seq #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (12),
    .NUM_REGS   (21)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .tbl_we_i   (tbl_we),
    .tbl_idx_i  (tbl_idx),
    .tbl_addr_i (tbl_addr),
    .tbl_data_i (tbl_data),
    .num_i      (num),
    .loops_i    (loops),
    .start_i    (start),
    .abort_i    (abort),
    .pg         (pg_if.master),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] a, input logic [31:0] d);
    check({tag, " valid"}, 64'(pg_if.cfg_pat_gen_o), 64'd1);
    check({tag, " addr"},  64'(pg_if.si_addr_o), 64'(a));
    check({tag, " data"},  64'(pg_if.ctl_pat_data_o), 64'(d));
  endtask

  task automatic wr(input int unsigned i, input logic [31:0] a, input logic [11:0] d);
    tbl_we   = 1'b1;
    tbl_idx  = 5'(i);
    tbl_addr = a;
    tbl_data = d;
    tick();
    tbl_we   = 1'b0;
  endtask

  task automatic do_start(input int unsigned n, input int unsigned l);
    num   = 6'(n);
    loops = 8'(l);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; tbl_we = 1'b0; tbl_idx = '0; tbl_addr = '0; tbl_data = '0;
    num = '0; loops = '0; start = 1'b0; abort = 1'b0; pg_if.nopg_i = 1'b0;
    tick(); tick();
    check("rst valid", 64'(pg_if.cfg_pat_gen_o), 64'd0);
    check("rst busy",  64'(busy), 64'd0);
    check("rst done",  64'(done), 64'd0);
    check("rst err",   64'(err), 64'd0);
    check("rst addr",  64'(pg_if.si_addr_o), 64'd0);
    check("rst data",  64'(pg_if.ctl_pat_data_o), 64'd0);
    rst_ni = 1'b1;

    for (int i = 0; i < 21; i++) wr(i, 32'h1000 + 32'(i), 12'(i));

    // num=3, loops=0
    do_start(3, 0);
    check_word("t1 w0", 32'h1000, 0);
    check("t1 busy", 64'(busy), 64'd1);
    tick(); check_word("t1 w1", 32'h1001, 1);
    tick(); check_word("t1 w2", 32'h1002, 2);
    check("t1 no early done", 64'(done), 64'd0);
    tick();
    check("t1 done", 64'(done), 64'd1);
    check("t1 valid off", 64'(pg_if.cfg_pat_gen_o), 64'd0);
    tick();
    check("t1 done once", 64'(done), 64'd0);
    check("t1 idle", 64'(busy), 64'd0);

    // num=2, loops=2 -> 0,1,0,1,0,1
    do_start(2, 2);
    for (int k = 0; k < 6; k++) begin
      check_word("t2 word", 32'h1000 + 32'(k % 2), 32'(k % 2));
      check("t2 busy", 64'(busy), 64'd1);
      check("t2 done low", 64'(done), 64'd0);
      tick();
    end
    check("t2 done", 64'(done), 64'd1);
    check("t2 valid off", 64'(pg_if.cfg_pat_gen_o), 64'd0);
    tick();

    // num=4 with a 3-cycle stall on word 1; table rewrites during the stall
    do_start(4, 0);
    check_word("t3 w0", 32'h1000, 0);
    tick();
    check_word("t3 w1", 32'h1001, 1);
    pg_if.nopg_i = 1'b1;
    wr(1, 32'hBEEF, 12'h0AA);
    check_word("t3 stall a", 32'h1001, 1);
    wr(2, 32'h2002, 12'h022);
    check_word("t3 stall b", 32'h1001, 1);
    tick();
    check_word("t3 stall c", 32'h1001, 1);
    pg_if.nopg_i = 1'b0;
    tick(); check_word("t3 w2 rewritten", 32'h2002, 32'h22);
    tick(); check_word("t3 w3", 32'h1003, 3);
    tick();
    check("t3 done", 64'(done), 64'd1);
    tick();
    wr(1, 32'h1001, 12'd1);
    wr(2, 32'h1002, 12'd2);
    wr(21, 32'hDEAD, 12'hFFF);  // out of range, dropped

    // bad starts
    do_start(0, 0);
    check("t4 err num0", 64'(err), 64'd1);
    check("t4 busy num0", 64'(busy), 64'd0);
    check("t4 valid num0", 64'(pg_if.cfg_pat_gen_o), 64'd0);
    do_start(22, 0);
    check("t4 err num22", 64'(err), 64'd1);
    check("t4 busy num22", 64'(busy), 64'd0);
    tick();
    check("t4 err sticky", 64'(err), 64'd1);
    do_start(1, 0);
    check("t4 err cleared", 64'(err), 64'd0);
    check_word("t4 w0", 32'h1000, 0);
    tick();
    check("t4 done", 64'(done), 64'd1);
    tick();

    // start ignored in DONE/RUN is implicitly covered; abort on third word
    do_start(5, 0);
    check_word("t5 w0", 32'h1000, 0);
    tick(); check_word("t5 w1", 32'h1001, 1);
    tick(); check_word("t5 w2", 32'h1002, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5 valid off", 64'(pg_if.cfg_pat_gen_o), 64'd0);
    check("t5 busy off", 64'(busy), 64'd0);
    check("t5 no done", 64'(done), 64'd0);
    tick();
    check("t5 no done later", 64'(done), 64'd0);
    check("t5 still idle", 64'(pg_if.cfg_pat_gen_o), 64'd0);

    // reset mid-run, then replay from entry 0
    do_start(5, 0);
    tick();
    check_word("t6 w1", 32'h1001, 1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check("t6 valid", 64'(pg_if.cfg_pat_gen_o), 64'd0);
    check("t6 busy",  64'(busy), 64'd0);
    check("t6 done",  64'(done), 64'd0);
    check("t6 addr",  64'(pg_if.si_addr_o), 64'd0);
    check("t6 data",  64'(pg_if.ctl_pat_data_o), 64'd0);
    tick();
    check("t6 no done after", 64'(done), 64'd0);
    do_start(2, 0);
    check_word("t6 replay w0", 32'h1000, 0);
    tick(); check_word("t6 replay w1", 32'h1001, 1);
    tick();
    check("t6 done", 64'(done), 64'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/pat_gen_seq.md
# pat_gen_seq

Initiator side of the pattern-generation interface: holds a programmable table of up to NUM_REGS address/data entries and plays them out, in index order and optionally repeated, as a stream of address/pattern words. It drives si_addr_o, ctl_pat_data_o and cfg_pat_gen_o toward the pattern consumer, and stalls on that consumer's nopg_i back-pressure. It sits between the control-register block, which programs the table and starts runs, and the pattern consumer.

## Interface
- ADDR_WIDTH, 32, address field width
- DATA_WIDTH, 12, stored pattern data width
- NUM_REGS, 21, table depth (entries), ≥1
- SUB_REGS_DATA_WIDTH, (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH, output pattern word width
- clk_i  in  1  single clock, all logic rising-edge
- rst_ni  in  1  synchronous, active-low reset
- tbl_we_i  in  1  table write strobe
- tbl_idx_i  in  IW = $clog2(NUM_REGS) (min 1)  table write index
- tbl_addr_i  in  ADDR_WIDTH  entry address
- tbl_data_i  in  DATA_WIDTH  entry data
- num_i  in  IW+1  entries per pass, 1..NUM_REGS
- loops_i  in  8  extra passes (0 = play once)
- start_i  in  1  start pulse
- abort_i  in  1  stop run
- nopg_i  in  1  consumer not ready; 1 = stall
- si_addr_o  out  ADDR_WIDTH  current entry address
- ctl_pat_data_o  out  SUB_REGS_DATA_WIDTH  current entry data, zero-extended
- cfg_pat_gen_o  out  1  word valid
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky: bad start parameters

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start_i with 1 ≤ num_i ≤ NUM_REGS → RUN.
  - num_i and loops_i are latched; idx = 0; pass counter = loops_i.
- start_i with num_i = 0 or num_i > NUM_REGS → err_o set, stay IDLE. err_o clears on the next valid start.
- RUN:
  - cfg_pat_gen_o = 1; outputs present the entry at idx.
  - A transfer occurs on any cycle with cfg_pat_gen_o = 1 and nopg_i = 0.
  - On transfer, idx increments. At idx = num-1, idx wraps to 0; if the pass counter is 0 → DONE, else the counter decrements.
- While nopg_i = 1, the address/data outputs hold stable and idx does not advance.
- abort_i in RUN → IDLE next cycle. cfg_pat_gen_o drops; there is no done_o pulse. A transfer in the same cycle counts, but no further word is issued.
- DONE: done_o = 1 for one cycle, then IDLE.
- start_i outside IDLE is ignored.
- busy_o = 1 in RUN.
- Table writes:
  - Writes are accepted in any state.
  - A write to the entry currently presented during a stall is not visible until the next transfer. The presented word is registered at the advance.
  - tbl_idx_i ≥ NUM_REGS → write dropped.
- Data is zero-extended from DATA_WIDTH to SUB_REGS_DATA_WIDTH.
- The table is not reset. Its contents are undefined until written.

## Timing
- Reset (rst_ni = 0 at a clock edge):
  - cfg_pat_gen_o = 0, busy_o = 0, done_o = 0, err_o = 0.
  - si_addr_o = 0, ctl_pat_data_o = 0.
  - State = IDLE; idx and pass counter = 0.
- Reset mid-run: the run is discarded with no done_o pulse.
- Latency: start_i at cycle N → cfg_pat_gen_o = 1 with entry 0 at N+1.
- No stalls: one word per cycle. Total words = num × (loops+1).
- Last transfer at cycle M → done_o at M+1 and cfg_pat_gen_o = 0 at M+1; IDLE at M+2.
- All outputs are registered; there is no combinational path from nopg_i to outputs.
- Write-then-read: a table write at cycle N is visible to the presented word from N+1.

## Structure
- Package pat_gen_pkg holds:
  - state enum (IDLE/RUN/DONE);
  - table entry struct {addr, data};
  - IW derivation helper.
- Sub-module pat_tbl: NUM_REGS-entry register array with one write port and one read port by idx, instantiated once.

## Test plan
- Table entry i = {addr = 0x1000 + i, data = i}; num = 3, loops = 0; nopg_i = 0 → 3 words in consecutive cycles: (0x1000, 0), (0x1001, 1), (0x1002, 2). done_o follows the last word by 1 cycle.
- num = 2, loops = 2, nopg_i = 0 → 6 words: pattern 0, 1, 0, 1, 0, 1; busy_o high throughout.
- num = 4; nopg_i = 1 for 3 cycles at word 1 → word 1 holds stable for 4 cycles. Total of 4 words, no duplicates or drops.
- start with num_i = 0, and start with num_i = 22 → err_o = 1, busy_o stays 0. A following valid start clears err_o.
- abort_i on the third word of num = 5 → cfg_pat_gen_o = 0 next cycle and no done_o.
- rst_ni = 0 mid-run → all outputs zero next cycle. A new start then replays from entry 0.
